// File: rtl/aes_ctr_ctrl_pkg.sv
// Shared types and helpers for the AES CTR-mode counter sequencer.
// The optional wrap flag is enabled by defining AES_CTR_WRAP_DETECT_EN.
package aes_ctr_ctrl_pkg;

  localparam int CtrWidth = 128;

  typedef enum logic [1:0] {
    CtrIdle = 2'd0,
    CtrIncr = 2'd1,
    CtrDone = 2'd2
  } aes_ctr_state_e;

  // ctr_o byte 0 is the most-significant numeric byte; reversal maps both ways.
  function automatic logic [CtrWidth-1:0] aes_ctr_rev_bytes(input logic [CtrWidth-1:0] d);
    logic [CtrWidth-1:0] r;
    r = '0;
    for (int i = 0; i < CtrWidth / 8; i++) begin
      r[8*i +: 8] = d[CtrWidth-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_ctr_slice_add.sv
// Narrow incrementer slice: adds a single carry bit to one counter slice.
// Used by aes_ctr_ctrl (wrap detection there is gated by AES_CTR_WRAP_DETECT_EN).
module aes_ctr_slice_add #(
  parameter int SliceWidth = 16
) (
  input  logic [SliceWidth-1:0] a_i,
  input  logic                  carry_i,
  output logic [SliceWidth-1:0] sum_o,
  output logic                  carry_o
);

  logic [SliceWidth:0] sum;

  assign sum = {1'b0, a_i} + {{SliceWidth{1'b0}}, carry_i};
  assign {carry_o, sum_o} = sum;

endmodule

// File: rtl/aes_ctr_ctrl.sv
// AES CTR counter owner: CSR byte writes in IDLE, constant-time slice-serial increment.
// Define AES_CTR_WRAP_DETECT_EN to build the sticky 128-bit wrap flag.
module aes_ctr_ctrl
  import aes_ctr_ctrl_pkg::*;
#(
  parameter int SliceWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                incr_req_i,
  output logic                incr_ack_o,
  output logic                busy_o,
  input  logic [CtrWidth-1:0] sw_ctr_i,
  input  logic [15:0]         sw_we_i,
  output logic                sw_ready_o,
  output logic [CtrWidth-1:0] ctr_o,
  output logic                wrap_o
);

  localparam int NumSlices = CtrWidth / SliceWidth;
  localparam int IdxW      = $clog2(NumSlices);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSlices - 1);

  localparam logic [1:0] StIdle = CtrIdle;
  localparam logic [1:0] StIncr = CtrIncr;
  localparam logic [1:0] StDone = CtrDone;

  logic [1:0]            state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic [CtrWidth-1:0]   n_q, n_d;
  logic [CtrWidth-1:0]   ctr_view, ctr_wr;
  logic [SliceWidth-1:0] slice_a, slice_sum;
  logic                  slice_cout;

  // The counter is held numerically; ctr_o is its byte-reversed view.
  assign ctr_view = aes_ctr_rev_bytes(n_q);
  assign slice_a  = n_q[idx_q*SliceWidth +: SliceWidth];

  aes_ctr_slice_add #(
    .SliceWidth(SliceWidth)
  ) u_slice_add (
    .a_i    (slice_a),
    .carry_i(carry_q),
    .sum_o  (slice_sum),
    .carry_o(slice_cout)
  );

  always_comb begin
    ctr_wr = ctr_view;
    for (int i = 0; i < CtrWidth / 8; i++) begin
      if (sw_we_i[i]) ctr_wr[8*i +: 8] = sw_ctr_i[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    n_d     = n_q;
    case (state_q)
      StIdle: begin
        n_d = aes_ctr_rev_bytes(ctr_wr);
        if (incr_req_i) begin
          state_d = StIncr;
          idx_d   = '0;
          carry_d = 1'b1;
        end
      end
      StIncr: begin
        // Every slice is visited regardless of carry so latency never leaks data.
        n_d[idx_q*SliceWidth +: SliceWidth] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
          idx_d   = '0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear_i) begin
      state_d = StIdle;
      idx_d   = '0;
      carry_d = 1'b0;
      n_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      n_q     <= n_d;
    end
  end

`ifdef AES_CTR_WRAP_DETECT_EN
  logic wrap_q, wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if (state_q == StIncr && idx_q == LastIdx && slice_cout) wrap_d = 1'b1;
    if (clear_i) wrap_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) wrap_q <= 1'b0;
    else         wrap_q <= wrap_d;
  end

  assign wrap_o = wrap_q;
`else
  assign wrap_o = 1'b0;
`endif

  assign ctr_o      = ctr_view;
  assign incr_ack_o = (state_q == StDone);
  assign busy_o     = (state_q == StIncr) || (state_q == StDone);
  assign sw_ready_o = (state_q == StIdle);

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Scoreboard bench for aes_ctr_ctrl with a numeric reference model of the counter.
// Wrap expectations follow AES_CTR_WRAP_DETECT_EN.
module tb_aes_ctr_ctrl;

  localparam int SW = 16;
  localparam int NS = 128 / SW;

  logic         clk = 1'b0;
  logic         rst_ni, clear_i, incr_req_i;
  logic         incr_ack_o, busy_o, sw_ready_o, wrap_o;
  logic [127:0] sw_ctr_i, ctr_o;
  logic [15:0]  sw_we_i;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [127:0] ctr;
    int           cyc;
    logic         wrap;
  } exp_t;
  exp_t sb[$];

  logic [127:0] mN;
  logic         mWrap;

  aes_ctr_ctrl #(.SliceWidth(SW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .incr_req_i(incr_req_i),
    .incr_ack_o(incr_ack_o),
    .busy_o    (busy_o),
    .sw_ctr_i  (sw_ctr_i),
    .sw_we_i   (sw_we_i),
    .sw_ready_o(sw_ready_o),
    .ctr_o     (ctr_o),
    .wrap_o    (wrap_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] rev(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = d[8*(15-i) +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte writes on the big-endian view, increment modulo 2^128.
  task automatic model_write(input logic [127:0] data, input logic [15:0] we);
    logic [127:0] c;
    c = rev(mN);
    for (int i = 0; i < 16; i++) if (we[i]) c[8*i +: 8] = data[8*i +: 8];
    mN = rev(c);
  endtask

  task automatic model_incr();
`ifdef AES_CTR_WRAP_DETECT_EN
    if (mN == {128{1'b1}}) mWrap = 1'b1;
`endif
    mN = mN + 128'd1;
  endtask

  // Scoreboard monitor: every ack must match the oldest expected result and cycle.
  always @(negedge clk) begin
    if (rst_ni && incr_ack_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_ctr", ctr_o, e.ctr);
        chk("ack_cycle", 128'(cyc), 128'(e.cyc));
        chk("ack_wrap", {127'd0, wrap_o}, {127'd0, e.wrap});
      end
    end
  end

  task automatic sw_write(input logic [127:0] data, input logic [15:0] we);
    chk("sw_ready_idle", {127'd0, sw_ready_o}, 128'd1);
    sw_ctr_i = data;
    sw_we_i  = we;
    @(negedge clk);
    sw_we_i = '0;
    model_write(data, we);
    chk("ctr_after_write", ctr_o, rev(mN));
  endtask

  task automatic do_incr(input int nacks, input logic [127:0] wdata,
                         input logic [15:0] we, input bit midwrite);
    int   c0, got, n;
    exp_t e;
    c0 = cyc;
    if (we != 16'd0) begin
      model_write(wdata, we);
      sw_ctr_i = wdata;
      sw_we_i  = we;
    end
    incr_req_i = 1'b1;
    for (int k = 0; k < nacks; k++) begin
      model_incr();
      e.ctr  = rev(mN);
      e.cyc  = c0 + 1 + NS + 10 * k;
      e.wrap = mWrap;
      sb.push_back(e);
    end
    got = 0;
    n   = 0;
    while (got < nacks && n < 30 * nacks + 30) begin
      @(negedge clk);
      n++;
      sw_we_i = '0;
      if (midwrite && n == 3) begin
        chk("sw_ready_busy", {127'd0, sw_ready_o}, 128'd0);
        sw_ctr_i = ~wdata;
        sw_we_i  = 16'hFFFF;
      end
      if (incr_ack_o) got++;
    end
    incr_req_i = 1'b0;
    sw_we_i    = '0;
    if (got < nacks) chk("ack_timeout", 128'(got), 128'(nacks));
    @(negedge clk);
    chk("idle_after_ack", {126'd0, busy_o, sw_ready_o}, 128'd1);
  endtask

  task automatic abort_incr(input bit use_rst);
    incr_req_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_before_abort", {127'd0, busy_o}, 128'd1);
    if (use_rst) rst_ni = 1'b0;
    else         clear_i = 1'b1;
    incr_req_i = 1'b0;
    @(negedge clk);
    rst_ni  = 1'b1;
    clear_i = 1'b0;
    mN      = '0;
    mWrap   = 1'b0;
    chk("abort_ctr", ctr_o, 128'd0);
    chk("abort_flags", {125'd0, busy_o, sw_ready_o, wrap_o}, 128'b010);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    logic [15:0]  we;
    rst_ni = 1'b0; clear_i = 1'b0; incr_req_i = 1'b0;
    sw_ctr_i = '0; sw_we_i = '0;
    mN = '0; mWrap = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    chk("reset_ctr", ctr_o, 128'd0);
    chk("reset_flags", {124'd0, incr_ack_o, busy_o, sw_ready_o, wrap_o}, 128'b0010);

    do_incr(1, '0, '0, 1'b0);
    chk("first_incr", rev(ctr_o), 128'd1);

    sw_write(rev(128'h0000_0000_0000_0000_0000_FFFF_FFFF_FFFF), 16'hFFFF);
    do_incr(1, '0, '0, 1'b0);
    chk("carry_chain", rev(ctr_o), 128'h0000_0000_0000_0000_0001_0000_0000_0000);

    sw_write({128{1'b1}}, 16'hFFFF);
    do_incr(1, '0, '0, 1'b0);
    chk("wrap_ctr", ctr_o, 128'd0);
    sw_write(rev(128'd77), 16'hFFFF);
    chk("wrap_sticky", {127'd0, wrap_o}, {127'd0, mWrap});
    clear_i  = 1'b1;
    sw_ctr_i = {128{1'b1}};
    sw_we_i  = 16'hFFFF;
    @(negedge clk);
    clear_i = 1'b0;
    sw_we_i = '0;
    mN = '0; mWrap = 1'b0;
    chk("clear_ctr", ctr_o, 128'd0);
    chk("clear_wrap", {127'd0, wrap_o}, 128'd0);

    sw_write(rev(128'd5), 16'hFFFF);
    do_incr(3, '0, '0, 1'b0);
    chk("back_to_back", rev(ctr_o), 128'd8);

    abort_incr(1'b0);
    do_incr(1, '0, '0, 1'b0);
    chk("after_clear", rev(ctr_o), 128'd1);
    abort_incr(1'b1);
    do_incr(1, '0, '0, 1'b0);
    chk("after_reset", rev(ctr_o), 128'd1);

    sw_write(rev(128'h1234), 16'hFFFF);
    do_incr(1, rev(128'h1234), '0, 1'b1);
    chk("write_dropped", rev(ctr_o), 128'h1235);

    d = rev(128'h00FF_0000_0000_0000_0000_0000_0000_00FF);
    do_incr(1, d, 16'hFFFF, 1'b0);
    chk("write_with_req", rev(ctr_o), 128'h00FF_0000_0000_0000_0000_0000_0000_0100);

    for (int it = 0; it < 12; it++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      we = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        d[127:64] = {64{1'b1}};
        we[15:8]  = 8'hFF;
      end
      if ($urandom_range(0, 1) == 1) begin
        do_incr($urandom_range(1, 2), d, we, 1'b0);
      end else begin
        sw_write(d, we);
        do_incr(1, '0, '0, $urandom_range(0, 1) == 1);
      end
      chk("rand_ctr", ctr_o, rev(mN));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/aes_ctr_ctrl.md
# aes_ctr_ctrl

Sequencer and owner of the 128-bit AES CTR-mode counter register. It accepts increment requests from the cipher control FSM and word writes from the register interface, and arbitrates between them. Increments run slice-serially over a narrow adder in a fixed, data-independent number of cycles, and write the result back into the counter. It sits between the AES control FSM, the CSR block and the data-input path that consumes `ctr_o`.

## Interface
Parameters:
- `SliceWidth`, 16: adder width per cycle. Legal values are 8, 16 and 32. `NumSlices = 128 / SliceWidth`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  synchronous active-low reset.
- `clear_i`  in  1  synchronous clear of the counter and abort of any increment.
- `incr_req_i`  in  1  increment request, level; held until `incr_ack_o`.
- `incr_ack_o`  out  1  one-cycle pulse; the incremented value is visible on `ctr_o` in the same cycle.
- `busy_o`  out  1  high in INCR and DONE.
- `sw_ctr_i`  in  128  write data from CSR.
- `sw_we_i`  in  16  per-byte write enables.
- `sw_ready_o`  out  1  high only in IDLE; writes with `sw_ready_o` low are dropped.
- `ctr_o`  out  128  counter value, big-endian byte order: `ctr_o[7:0]` is the most-significant byte.
- `wrap_o`  out  1  sticky flag: the full 128-bit counter wrapped.

## Operation
- Numeric counter `N` = byte-reversed `ctr_o`. Slice k is `N[k*SliceWidth +: SliceWidth]`.
- States:
  - IDLE: `sw_ready_o`=1. Byte writes from `sw_we_i` apply at the clock edge.
  - IDLE → INCR: when `incr_req_i`=1 at an edge. On entry, slice index = 0 and carry = 1.
  - INCR: each cycle computes slice k + carry, writes slice k of the counter, and latches the carry out. The index increments each cycle.
  - INCR → DONE: after slice `NumSlices-1` is written.
  - DONE: `incr_ack_o`=1, then DONE → IDLE unconditionally.
- Constant time: all `NumSlices` slices are always processed, even when the carry is already 0. There is no early exit.
- Simultaneous software write and request in IDLE: the write is applied at the edge and the increment starts from the written value on the next cycle. The request stays pending because it is a level.
- Back-to-back requests: if `incr_req_i` is still high in the IDLE cycle after DONE, a new increment starts.
- `clear_i` has the highest priority in every state:
  - counter ← 0, state ← IDLE, index ← 0, carry ← 0, `wrap_o` ← 0.
  - No ack is issued for an aborted increment, and any software write in that cycle is ignored.
- Arithmetic: the slice sum is `SliceWidth+1` bits wide and the MSB is the carry. The carry out of the last slice is discarded from `N` (modulo 2^128) and feeds the wrap logic.

## Timing
- Reset values: counter 0, IDLE, `incr_ack_o`=0, `busy_o`=0, `sw_ready_o`=1, `wrap_o`=0, `ctr_o`=0.
- Request sampled at edge T:
  - INCR occupies cycles T+1 … T+NumSlices.
  - `incr_ack_o` is high in cycle T+NumSlices+1. For the default `SliceWidth` of 16, that is 9 cycles after the sampling edge.
- While INCR runs, `ctr_o` shows partially updated slices. Consumers sample `ctr_o` only on `incr_ack_o` or in IDLE.
- Reset or clear in the middle of an increment takes effect at the next edge. No ack follows.
- All outputs are driven from registers or the state decode, with no combinational path from any input to any output.

## Configuration
- `AES_CTR_WRAP_DETECT_EN` defined:
  - `wrap_o` is set when the last-slice carry out is 1 (counter 2^128−1 → 0).
  - It stays set until reset or `clear_i`. A software write does not clear it.
- Undefined: `wrap_o` is tied to 0 and no wrap logic is generated. Increment behaviour is otherwise identical.

## Structure
- Package `aes_ctr_ctrl_pkg` holds:
  - the state enum (IDLE, INCR, DONE);
  - the localparam `CtrWidth = 128`;
  - the `aes_ctr_rev_bytes(128)` function.
- Sub-module `aes_ctr_slice_add`: a parameterised `SliceWidth` adder with carry in and carry out, instantiated once.
- The top level holds the FSM, index and carry registers, the counter register, the write-enable mux and the wrap flag.

## Test plan
- Reset, then `N`=0x00..00 and one request: ack 9 cycles after the sampling edge, `N`=0x00..01, `wrap_o`=0.
- Software writes `N`=0x0000_FFFF_FFFF_FFFF, then request: result `N`=0x0001_0000_0000_0000 and latency is still 9 cycles (constant time).
- `N`=0xFF..FF, then request: `N`=0. With the macro, `wrap_o`=1 until `clear_i`; without it, `wrap_o`=0.
- `incr_req_i` held for three acks starting from `N`=5: three ack pulses spaced 10 cycles apart, final `N`=8.
- `clear_i` in the 4th INCR cycle: no ack, `N`=0, next request yields `N`=1. Repeat with `rst_ni` low in place of `clear_i`: same result.
- Software write with `sw_we_i`=0xFFFF during INCR: dropped, `sw_ready_o`=0. The same write in the same IDLE cycle as a request: increment applies to the written value.
